alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked execute-stage ALU that generalises the 2-bit combinational ALU with configurable datapath width, a 4-bit command set and registered output. It adds subtract, set-less-than and shift commands. Shifts run on an iterative multi-cycle shifter moving up to SHIFT_STEP bits per cycle. The block sits in EXE between the decode/issue register and the memory-stage register, and stalls issue through valid/ready.

## Interface
- WIDTH, 32: datapath width; power of two, ≥ 8.
- SHIFT_STEP, 8: maximum bits shifted per cycle; power of two, 1..WIDTH.
- CLK  in  1  clock, all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- OP1_SE  in  WIDTH  operand 1.
- OP2_SE  in  WIDTH  operand 2; the low log2(WIDTH) bits are the shift amount for shift commands.
- CIN_SE  in  1  carry-in, used by ADD only.
- CMD_SE  in  4  command code.
- IN_VALID_SE  in  1  operands and command are valid.
- IN_READY_SE  out  1  block accepts an operation this cycle.
- RES_SE  out  WIDTH  registered result.
- COUT_SE  out  1  registered carry-out.
- OUT_VALID_SE  out  1  RES_SE and COUT_SE are valid.
- OUT_READY_SE  in  1  consumer accepts the result.
- BUSY_SE  out  1  high while in SHIFT.

## Operation
- An operation is accepted on an edge where IN_VALID_SE && IN_READY_SE. Operands are captured at that edge, and input changes afterwards have no effect.
- Commands:
  - 0 ADD: OP1+OP2+CIN, COUT = carry out of the MSB.
  - 1 AND, 2 OR, 3 XOR: bitwise.
  - 4 SUB: OP1+~OP2+1, CIN ignored, COUT=1 means no borrow.
  - 5 SLT: signed compare, result 1 or 0.
  - 6 SLTU: unsigned compare, result 1 or 0.
  - 7 SLL, 8 SRL, 9 SRA: shift OP1 by amount n = OP2[log2(WIDTH)-1:0].
  - 10..15: RES=0, COUT=0, latency as for a logic op.
- COUT=0 for every command except ADD and SUB.
- All arithmetic is modulo 2^WIDTH. There is no overflow flag.
- FSM states are IDLE, SHIFT, DONE.
- From IDLE, on accept:
  - non-shift command, or shift with n=0: result registered (n=0 gives OP1 unchanged), next state DONE.
  - shift with n>0: work register = OP1, counter = n, next state SHIFT.
- In SHIFT, each edge shifts the work register by s = min(counter, SHIFT_STEP) and sets counter -= s.
  - SRA fills with the original sign bit; SLL and SRL fill with zeros.
  - When counter reaches 0, next state DONE.
- In DONE, OUT_VALID_SE=1 and RES_SE/COUT_SE are held stable until OUT_READY_SE.
  - On OUT_READY_SE with IN_VALID_SE: the new operation is accepted on the same edge and is processed as from IDLE.
  - On OUT_READY_SE without IN_VALID_SE: next state IDLE.
- IN_READY_SE = (state==IDLE) || (state==DONE && OUT_READY_SE). It is combinational from OUT_READY_SE, and low throughout SHIFT.
- RESET forces state IDLE and discards any operation in flight, including one in SHIFT or DONE.
  - Values after reset: RES_SE=0, COUT_SE=0, OUT_VALID_SE=0, BUSY_SE=0, counter 0, IN_READY_SE=1.
- RESET has priority over a simultaneous accept; the accept is dropped.

## Timing
- Non-shift command or n=0: accept at edge k, OUT_VALID_SE high after edge k+1, giving latency 1.
- Shift with n>0: OUT_VALID_SE high after edge k+1+ceil(n/SHIFT_STEP). BUSY_SE is high for ceil(n/SHIFT_STEP) cycles.
- Throughput with OUT_READY_SE held high: one non-shift operation per cycle.
- There is no combinational path from OP*/CMD_SE to any output. The only combinational path is OUT_READY_SE → IN_READY_SE.

## Test plan
- Carry: ADD with OP1=0xFFFFFFFF, OP2=0x1, CIN=1 → RES=0x00000001, COUT=1, OUT_VALID_SE one cycle after accept.
- Subtract and compares:
  - SUB 5−7 → 0xFFFFFFFE, COUT=0.
  - SLT with OP1=0x80000000, OP2=1 → 1.
  - SLTU with the same operands → 0.
  - CMD=15 → RES=0, COUT=0.
- Shift latency (WIDTH=32, SHIFT_STEP=8):
  - SRA 0x80000000 by 20 → 0xFFFFF800, OUT_VALID_SE 4 cycles after accept. BUSY_SE high 3 cycles, IN_READY_SE low during SHIFT.
  - SLL 0x1 by 31 → 0x80000000 after 5 cycles.
  - SRL by 0 → OP1 after 1 cycle.
- Back-pressure: hold OUT_READY_SE=0 for 5 cycles in DONE.
  - Required: RES_SE stable, IN_READY_SE=0.
  - Then raise OUT_READY_SE with IN_VALID_SE=1: next operation accepted on the same edge, its result valid the following cycle.
- Streaming: 8 back-to-back ADDs with OUT_READY_SE=1 → 8 results on 8 consecutive cycles, in order, no bubbles.
- Reset mid-shift: assert RESET during SHIFT of SRL by 31.
  - Required next cycle: all outputs 0, IN_READY_SE=1, no stale OUT_VALID_SE afterwards.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with registered result and an iterative shifter
// that moves up to SHIFT_STEP bits per cycle.
module alu_seq #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] OP1_SE,
    input  logic [WIDTH-1:0] OP2_SE,
    input  logic             CIN_SE,
    input  logic [3:0]       CMD_SE,
    input  logic             IN_VALID_SE,
    output logic             IN_READY_SE,
    output logic [WIDTH-1:0] RES_SE,
    output logic             COUT_SE,
    output logic             OUT_VALID_SE,
    input  logic             OUT_READY_SE,
    output logic             BUSY_SE
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;
    localparam int unsigned W1 = WIDTH + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    localparam logic [3:0] CMD_ADD  = 4'd0;
    localparam logic [3:0] CMD_AND  = 4'd1;
    localparam logic [3:0] CMD_OR   = 4'd2;
    localparam logic [3:0] CMD_XOR  = 4'd3;
    localparam logic [3:0] CMD_SUB  = 4'd4;
    localparam logic [3:0] CMD_SLT  = 4'd5;
    localparam logic [3:0] CMD_SLTU = 4'd6;
    localparam logic [3:0] CMD_SLL  = 4'd7;
    localparam logic [3:0] CMD_SRL  = 4'd8;
    localparam logic [3:0] CMD_SRA  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  res_q;
    logic              cout_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [WIDTH-1:0]  work;
    logic [CW-1:0]     cnt;
    logic [3:0]        shop;

    logic              in_ready_c;
    logic              accept_c;
    logic [SW-1:0]     amt_c;
    logic              is_shift_c;
    logic [W1-1:0]     sum_c;
    logic [W1-1:0]     diff_c;
    logic [WIDTH-1:0]  alu_res_c;
    logic              alu_cout_c;
    logic [CW-1:0]     step_c;
    logic              last_c;
    logic signed [WIDTH-1:0] swork_c;
    logic [WIDTH-1:0]  shifted_c;

    // Ready is the only combinational output: a held result frees the slot as it drains.
    assign in_ready_c = (state == IDLE) || ((state == DONE) && OUT_READY_SE);
    assign accept_c   = IN_VALID_SE && in_ready_c;
    assign amt_c      = OP2_SE[SW-1:0];
    assign is_shift_c = (CMD_SE == CMD_SLL) || (CMD_SE == CMD_SRL) || (CMD_SE == CMD_SRA);

    // Single-cycle result; shifts only land here with a zero amount, so they pass OP1.
    always_comb begin
        alu_res_c  = '0;
        alu_cout_c = 1'b0;
        sum_c      = {1'b0, OP1_SE} + {1'b0, OP2_SE} + W1'(CIN_SE);
        diff_c     = {1'b0, OP1_SE} + {1'b0, ~OP2_SE} + W1'(1'b1);
        case (CMD_SE)
            CMD_ADD: begin
                alu_res_c  = sum_c[WIDTH-1:0];
                alu_cout_c = sum_c[WIDTH];
            end
            CMD_AND:  alu_res_c = OP1_SE & OP2_SE;
            CMD_OR:   alu_res_c = OP1_SE | OP2_SE;
            CMD_XOR:  alu_res_c = OP1_SE ^ OP2_SE;
            CMD_SUB: begin
                alu_res_c  = diff_c[WIDTH-1:0];
                alu_cout_c = diff_c[WIDTH];
            end
            CMD_SLT:  alu_res_c = WIDTH'($signed(OP1_SE) < $signed(OP2_SE));
            CMD_SLTU: alu_res_c = WIDTH'(OP1_SE < OP2_SE);
            CMD_SLL, CMD_SRL, CMD_SRA: alu_res_c = OP1_SE;
            default: begin
                alu_res_c  = '0;
                alu_cout_c = 1'b0;
            end
        endcase
    end

    // One bounded shift step; the sign bit survives each arithmetic step unchanged.
    always_comb begin
        step_c  = (cnt > STEP) ? STEP : cnt;
        last_c  = (cnt <= STEP);
        swork_c = work;
        case (shop)
            CMD_SLL: shifted_c = work << step_c;
            CMD_SRL: shifted_c = work >> step_c;
            default: shifted_c = swork_c >>> step_c;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            res_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            work        <= '0;
            cnt         <= '0;
            shop        <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept_c) begin
                        if (is_shift_c && (amt_c != '0)) begin
                            work        <= OP1_SE;
                            cnt         <= CW'(amt_c);
                            shop        <= CMD_SE;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                            state       <= SHIFT;
                        end else begin
                            res_q       <= alu_res_c;
                            cout_q      <= alu_cout_c;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end else if ((state == DONE) && OUT_READY_SE) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                SHIFT: begin
                    work <= shifted_c;
                    cnt  <= cnt - step_c;
                    if (last_c) begin
                        res_q       <= shifted_c;
                        cout_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY_SE  = in_ready_c;
    assign RES_SE       = res_q;
    assign COUT_SE      = cout_q;
    assign OUT_VALID_SE = out_valid_q;
    assign BUSY_SE      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against a plain-arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op1, op2;
    logic        cin;
    logic [3:0]  cmd;
    logic        in_valid, in_ready;
    logic [31:0] res;
    logic        cout;
    logic        out_valid, out_ready, busy;

    int checks = 0;
    int passed = 0;

    alu_seq #(.WIDTH(32), .SHIFT_STEP(8)) dut (
        .CLK(clk), .RESET(reset),
        .OP1_SE(op1), .OP2_SE(op2), .CIN_SE(cin), .CMD_SE(cmd),
        .IN_VALID_SE(in_valid), .IN_READY_SE(in_ready),
        .RES_SE(res), .COUT_SE(cout),
        .OUT_VALID_SE(out_valid), .OUT_READY_SE(out_ready),
        .BUSY_SE(busy)
    );

    always #5 clk = ~clk;

    // Reference: {cout, result} from the command definitions.
    function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci);
        logic [31:0] r;
        logic        co;
        logic signed [31:0] sa;
        longint unsigned wide;
        int n;
        n  = int'(b[4:0]);
        sa = a;
        r  = 32'd0;
        co = 1'b0;
        case (c)
            4'd0: begin
                wide = 64'(a) + 64'(b) + 64'(ci);
                r  = wide[31:0];
                co = wide[32];
            end
            4'd1: r = a & b;
            4'd2: r = a | b;
            4'd3: r = a ^ b;
            4'd4: begin
                r  = a - b;
                co = (a >= b);
            end
            4'd5: r = (sa < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            4'd7: r = a << n;
            4'd8: r = a >> n;
            4'd9: r = sa >>> n;
            default: r = 32'd0;
        endcase
        return {co, r};
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        if ((c >= 4'd7) && (c <= 4'd9) && (n > 0)) return 1 + (n + 7) / 8;
        return 1;
    endfunction

    // Issue one op from idle and wait (bounded) for its result; leaves it held in DONE.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, output logic [31:0] r, output logic co,
                          output int lat, output int busy_n, output int rdy_n);
        op1 = a; op2 = b; cin = ci; cmd = c;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op1 = $urandom; op2 = $urandom; cmd = 4'($urandom); cin = 1'($urandom);
        lat = 1; busy_n = 0; rdy_n = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_n++;
            if (in_ready) rdy_n++;
            @(posedge clk); #1;
            lat++;
        end
        r = res; co = cout;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cmd = 4'd0; op1 = 32'hFFFF_FFFF; op2 = 32'd5; cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (res !== 32'd0) $display("FAIL reset_res got %h want 0", res); else passed++;
        checks++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else passed++;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [3:0]  tc [5] = '{4'd0, 4'd4, 4'd5, 4'd6, 4'd15};
        logic [31:0] ta [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] tb [5] = '{32'd1, 32'd7, 32'd1, 32'd1, 32'hFFFF_FFFF};
        logic        ti [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] er [5] = '{32'd1, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'd0};
        logic        ec [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] r;
        logic co;
        int lat, bn, rn;
        for (int i = 0; i < 5; i++) begin
            run_op(tc[i], ta[i], tb[i], ti[i], r, co, lat, bn, rn);
            checks++; if (r !== er[i]) $display("FAIL arith_res[%0d] got %h want %h", i, r, er[i]); else passed++;
            checks++; if (co !== ec[i]) $display("FAIL arith_cout[%0d] got %b want %b", i, co, ec[i]); else passed++;
            checks++; if (lat != 1) $display("FAIL arith_lat[%0d] got %0d want 1", i, lat); else passed++;
            drain();
        end
    endtask

    task automatic test_shift();
        logic [3:0]  tc [3] = '{4'd9, 4'd7, 4'd8};
        logic [31:0] ta [3] = '{32'h8000_0000, 32'd1, 32'h1234_5678};
        logic [31:0] tb [3] = '{32'd20, 32'd31, 32'hFFFF_FFE0};
        logic [31:0] er [3] = '{32'hFFFF_F800, 32'h8000_0000, 32'h1234_5678};
        int          el [3] = '{4, 5, 1};
        int          eb [3] = '{3, 4, 0};
        logic [31:0] r;
        logic co;
        int lat, bn, rn;
        for (int i = 0; i < 3; i++) begin
            run_op(tc[i], ta[i], tb[i], 1'b1, r, co, lat, bn, rn);
            checks++; if (r !== er[i]) $display("FAIL shift_res[%0d] got %h want %h", i, r, er[i]); else passed++;
            checks++; if (co !== 1'b0) $display("FAIL shift_cout[%0d] got %b want 0", i, co); else passed++;
            checks++; if (lat != el[i]) $display("FAIL shift_lat[%0d] got %0d want %0d", i, lat, el[i]); else passed++;
            checks++; if (bn != eb[i]) $display("FAIL shift_busy[%0d] got %0d want %0d", i, bn, eb[i]); else passed++;
            checks++; if (rn != 0) $display("FAIL shift_ready_low[%0d] ready seen %0d cycles want 0", i, rn); else passed++;
            drain();
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r;
        logic [3:0]  c;
        logic        ci, co;
        logic [32:0] exp;
        int lat, bn, rn, elat;
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom; ci = 1'($urandom);
            if (i % 5 == 0) b = a;
            exp  = model(c, a, b, ci);
            elat = model_lat(c, b);
            run_op(c, a, b, ci, r, co, lat, bn, rn);
            checks++; if (r !== exp[31:0]) $display("FAIL rand_res[%0d] cmd %0d got %h want %h", i, c, r, exp[31:0]); else passed++;
            checks++; if (co !== exp[32]) $display("FAIL rand_cout[%0d] cmd %0d got %b want %b", i, c, co, exp[32]); else passed++;
            checks++; if (lat != elat) $display("FAIL rand_lat[%0d] cmd %0d got %0d want %0d", i, c, lat, elat); else passed++;
            drain();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, r, held;
        logic co;
        logic [32:0] exp;
        int lat, bn, rn;
        a = $urandom; b = $urandom;
        exp = model(4'd0, a, b, 1'b0);
        run_op(4'd0, a, b, 1'b0, r, co, lat, bn, rn);
        held = r;
        checks++; if (held !== exp[31:0]) $display("FAIL bp_first got %h want %h", held, exp[31:0]); else passed++;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res !== held || in_ready !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL bp_hold[%0d] res %h ready %b valid %b want res %h ready 0 valid 1",
                         i, res, in_ready, out_valid, held);
            else passed++;
            @(posedge clk); #1;
        end
        a = $urandom; b = $urandom;
        exp = model(4'd3, a, b, 1'b0);
        op1 = a; op2 = b; cmd = 4'd3; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_comb got %b want 1", in_ready); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || res !== exp[31:0])
            $display("FAIL bp_next valid %b res %h want valid 1 res %h", out_valid, res, exp[31:0]);
        else passed++;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp [8];
        logic [31:0] a, b;
        logic ci;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom);
            exp[i] = model(4'd0, a, b, ci);
            op1 = a; op2 = b; cin = ci; cmd = 4'd0; in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); else passed++;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || {cout, res} !== exp[i])
                $display("FAIL b2b_res[%0d] valid %b got %h want %h", i, out_valid, {cout, res}, exp[i]);
            else passed++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain valid got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_mid_shift();
        int stale;
        op1 = 32'hF000_0001; op2 = 32'd31; cmd = 4'd8; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL mid_shift busy %b ready %b want busy 1 ready 0", busy, in_ready);
        else passed++;
        reset = 1'b1; in_valid = 1'b1; cmd = 4'd0; op1 = 32'd3; op2 = 32'd4;
        @(posedge clk); #1;
        checks++;
        if (res !== 32'd0 || cout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_shift res %h cout %b valid %b busy %b ready %b want 0 0 0 0 1",
                     res, cout, out_valid, busy, in_ready);
        else passed++;
        reset = 1'b0; in_valid = 1'b0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
        end
        checks++; if (stale != 0) $display("FAIL rst_stale got %0d stale cycles want 0", stale); else passed++;
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; cin = 1'b0; cmd = '0;
        test_reset();
        test_arith();
        test_shift();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
